// File: rtl/spiker_result_collector_if.sv
// Spike word handshake bundle between the spiking core (master) and the result collector (slave).
// Transfer happens on a clock edge where spike_valid_i and spike_ready_o are both high.
interface spiker_result_collector_if #(
    parameter int WIDTH = 32
) ();
    logic             spike_valid_i;
    logic [WIDTH-1:0] spike_data_i;
    logic             spike_ready_o;

    modport master (
        output spike_valid_i,
        output spike_data_i,
        input  spike_ready_o
    );

    modport slave (
        input  spike_valid_i,
        input  spike_data_i,
        output spike_ready_o
    );
endinterface

// File: rtl/spiker_result_collector.sv
// Purpose: packs N_REG serial spike words into one frame and strobes sample_o; optional popcount via SPIKER_COLLECT_POPCOUNT_EN.
// Latency: sample_o rises the cycle after the last accepted word (frame >= N_REG+1 cycles).
// Backpressure: spike_ready_o is high only in COLLECT; words offered while idle are dropped and flagged.
module spiker_result_collector #(
    parameter int WIDTH      = 32,
    parameter int N_REG      = 24,
    parameter int DATA_WIDTH = 768,
    localparam int CNT_W     = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  test_mode_i,
    input  logic                  start_i,
    spiker_result_collector_if.slave spike,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  sample_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  overflow_o,
    output logic [CNT_W-1:0]      spike_count_o
);
    localparam int IDX_W = (N_REG > 1) ? $clog2(N_REG) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REG - 1);

    if (DATA_WIDTH != N_REG * WIDTH) begin : g_width_check
        $error("spiker_result_collector: DATA_WIDTH must equal N_REG*WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PUBLISH = 2'd2
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             hs;

    logic unused_test_mode;
    assign unused_test_mode = test_mode_i;

    assign spike.spike_ready_o = (state == COLLECT);
    assign hs       = spike.spike_valid_i && (state == COLLECT);
    assign sample_o = (state == PUBLISH);
    assign busy_o   = (state != IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            idx        <= '0;
            data_o     <= '0;
            done_o     <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state      <= COLLECT;
                        idx        <= '0;
                        done_o     <= 1'b0;
                        overflow_o <= 1'b0;
                    end else if (spike.spike_valid_i) begin
                        overflow_o <= 1'b1;
                    end
                end
                COLLECT: begin
                    // A restart wins over a word arriving in the same cycle.
                    if (start_i) begin
                        idx <= '0;
                    end else if (hs) begin
                        data_o[int'(idx)*WIDTH +: WIDTH] <= spike.spike_data_i;
                        if (idx == LAST_IDX) begin
                            state <= PUBLISH;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                PUBLISH: begin
                    state  <= IDLE;
                    done_o <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SPIKER_COLLECT_POPCOUNT_EN
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (start_i && (state != PUBLISH)) begin
            count_q <= '0;
        end else if (hs) begin
            count_q <= count_q + CNT_W'($countones(spike.spike_data_i));
        end
    end

    assign spike_count_o = count_q;
`else
    assign spike_count_o = '0;
`endif

endmodule
